lcd_timing_gen: RTL



---
 rtl/lcd_timing_pkg.sv | 45 ++++
 rtl/lcd_hv_counter.sv | 70 +++++++
 rtl/lcd_timing_gen.sv | 119 +++++++++++
 3 files changed

// File: rtl/lcd_timing_pkg.sv
// ============================================================================
//  Module      : lcd_timing_pkg
//  Description : Shared timing constants, field layout and types for the
//                800x480 RGB LCD timing generator.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package lcd_timing_pkg;

    localparam int c_H_ACTIVE = 800;
    localparam int c_H_FP     = 40;
    localparam int c_H_SYNC   = 128;
    localparam int c_H_BP     = 88;
    localparam int c_H_TOTAL  = c_H_ACTIVE + c_H_FP + c_H_SYNC + c_H_BP;

    localparam int c_V_ACTIVE = 480;
    localparam int c_V_FP     = 13;
    localparam int c_V_SYNC   = 3;
    localparam int c_V_BP     = 29;
    localparam int c_V_TOTAL  = c_V_ACTIVE + c_V_FP + c_V_SYNC + c_V_BP;

    localparam int c_H_CNT_W  = 11;
    localparam int c_V_CNT_W  = 10;

    // RGB565 layout: red in the top bits, blue in the bottom bits
    localparam int c_PIX_W    = 16;
    localparam int c_R_W      = 5;
    localparam int c_G_W      = 6;
    localparam int c_B_W      = 5;
    localparam int c_R_LSB    = 11;
    localparam int c_G_LSB    = 5;
    localparam int c_B_LSB    = 0;

    // Per-position decode carried down the output pipeline
    typedef struct packed {
        logic first;
        logic active;
        logic hs;
        logic vs;
    } tim_flags_t;

endpackage

`default_nettype wire

// File: rtl/lcd_hv_counter.sv
// ============================================================================
//  Module      : lcd_hv_counter
//  Description : Horizontal/vertical raster counters with active, sync and
//                frame-origin decode of the current position.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module lcd_hv_counter
    import lcd_timing_pkg::*;
#(
    parameter int H_ACTIVE = c_H_ACTIVE,
    parameter int H_FP     = c_H_FP,
    parameter int H_SYNC   = c_H_SYNC,
    parameter int H_BP     = c_H_BP,
    parameter int V_ACTIVE = c_V_ACTIVE,
    parameter int V_FP     = c_V_FP,
    parameter int V_SYNC   = c_V_SYNC,
    parameter int V_BP     = c_V_BP
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic [c_H_CNT_W-1:0] o_h_cnt,
    output logic [c_V_CNT_W-1:0] o_v_cnt,
    output tim_flags_t           o_flags
);

    localparam int c_HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [c_H_CNT_W-1:0] c_H_LAST   = c_H_CNT_W'(c_HT - 1);
    localparam logic [c_H_CNT_W-1:0] c_H_ACT    = c_H_CNT_W'(H_ACTIVE);
    localparam logic [c_H_CNT_W-1:0] c_HS_START = c_H_CNT_W'(H_ACTIVE + H_FP);
    localparam logic [c_H_CNT_W-1:0] c_HS_END   = c_H_CNT_W'(H_ACTIVE + H_FP + H_SYNC);

    localparam logic [c_V_CNT_W-1:0] c_V_LAST   = c_V_CNT_W'(c_VT - 1);
    localparam logic [c_V_CNT_W-1:0] c_V_ACT    = c_V_CNT_W'(V_ACTIVE);
    localparam logic [c_V_CNT_W-1:0] c_VS_START = c_V_CNT_W'(V_ACTIVE + V_FP);
    localparam logic [c_V_CNT_W-1:0] c_VS_END   = c_V_CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [c_H_CNT_W-1:0] r_h_cnt;
    logic [c_V_CNT_W-1:0] r_v_cnt;

    // Line and frame wrap happen on the same edge, so (last,last) -> (0,0)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (r_h_cnt == c_H_LAST) begin
            r_h_cnt <= '0;
            r_v_cnt <= (r_v_cnt == c_V_LAST) ? '0 : r_v_cnt + 1'b1;
        end else begin
            r_h_cnt <= r_h_cnt + 1'b1;
        end
    end

    always_comb begin
        o_flags        = '0;
        o_flags.first  = (r_h_cnt == '0) && (r_v_cnt == '0);
        o_flags.active = (r_h_cnt < c_H_ACT) && (r_v_cnt < c_V_ACT);
        o_flags.hs     = (r_h_cnt >= c_HS_START) && (r_h_cnt < c_HS_END);
        o_flags.vs     = (r_v_cnt >= c_VS_START) && (r_v_cnt < c_VS_END);
    end

    assign o_h_cnt = r_h_cnt;
    assign o_v_cnt = r_v_cnt;

endmodule

`default_nettype wire

// File: rtl/lcd_timing_gen.sv
// ============================================================================
//  Module      : lcd_timing_gen
//  Description : Pixel-clock timing generator: issues pixel requests one cycle
//                ahead and drives DE/HS/VS/RGB565 onto the LCD pins.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module lcd_timing_gen
    import lcd_timing_pkg::*;
#(
    parameter int   H_ACTIVE = c_H_ACTIVE,
    parameter int   H_FP     = c_H_FP,
    parameter int   H_SYNC   = c_H_SYNC,
    parameter int   H_BP     = c_H_BP,
    parameter int   V_ACTIVE = c_V_ACTIVE,
    parameter int   V_FP     = c_V_FP,
    parameter int   V_SYNC   = c_V_SYNC,
    parameter int   V_BP     = c_V_BP,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 pix_req,
    output logic [c_H_CNT_W-1:0] pix_x,
    output logic [c_V_CNT_W-1:0] pix_y,
    output logic                 frame_start,
    input  logic [c_PIX_W-1:0]   pix_data,
    output logic                 lcd_de,
    output logic                 lcd_hs,
    output logic                 lcd_vs,
    output logic [c_R_W-1:0]     lcd_r,
    output logic [c_G_W-1:0]     lcd_g,
    output logic [c_B_W-1:0]     lcd_b
);

    logic [c_H_CNT_W-1:0] w_h_cnt;
    logic [c_V_CNT_W-1:0] w_v_cnt;
    tim_flags_t           w_flags;

    tim_flags_t           r_s1;
    tim_flags_t           r_s2;
    logic [c_H_CNT_W-1:0] r_pix_x;
    logic [c_V_CNT_W-1:0] r_pix_y;
    logic                 r_lcd_de;
    logic                 r_lcd_hs;
    logic                 r_lcd_vs;
    logic [c_R_W-1:0]     r_lcd_r;
    logic [c_G_W-1:0]     r_lcd_g;
    logic [c_B_W-1:0]     r_lcd_b;

    lcd_hv_counter #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_hv_counter (
        .clk     (clk),
        .rst     (rst),
        .o_h_cnt (w_h_cnt),
        .o_v_cnt (w_v_cnt),
        .o_flags (w_flags)
    );

    // Request stage: coordinates hold their last value outside the active area
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1    <= '0;
            r_pix_x <= '0;
            r_pix_y <= '0;
        end else begin
            r_s1 <= w_flags;
            if (w_flags.active) begin
                r_pix_x <= w_h_cnt;
                r_pix_y <= w_v_cnt;
            end
        end
    end

    // Stage 2 spans the source's one-cycle latency; stage 3 is the pin register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2     <= '0;
            r_lcd_de <= 1'b0;
            r_lcd_hs <= ~HS_POL;
            r_lcd_vs <= ~VS_POL;
            r_lcd_r  <= '0;
            r_lcd_g  <= '0;
            r_lcd_b  <= '0;
        end else begin
            r_s2     <= r_s1;
            r_lcd_de <= r_s2.active;
            r_lcd_hs <= r_s2.hs ? HS_POL : ~HS_POL;
            r_lcd_vs <= r_s2.vs ? VS_POL : ~VS_POL;
            r_lcd_r  <= r_s2.active ? pix_data[c_R_LSB +: c_R_W] : '0;
            r_lcd_g  <= r_s2.active ? pix_data[c_G_LSB +: c_G_W] : '0;
            r_lcd_b  <= r_s2.active ? pix_data[c_B_LSB +: c_B_W] : '0;
        end
    end

    assign pix_req     = r_s1.active;
    assign frame_start = r_s1.first;
    assign pix_x       = r_pix_x;
    assign pix_y       = r_pix_y;
    assign lcd_de      = r_lcd_de;
    assign lcd_hs      = r_lcd_hs;
    assign lcd_vs      = r_lcd_vs;
    assign lcd_r       = r_lcd_r;
    assign lcd_g       = r_lcd_g;
    assign lcd_b       = r_lcd_b;

endmodule

`default_nettype wire
